// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
// Shared AXI4 constants and types for the CPU-to-AXI master wrapper and the
// interface bundle that carries its bus signals.
//   - Field widths for LEN/SIZE/BURST/RESP
//   - Burst/size/response encodings
//   - Master FSM state enum
//   - Helper that classifies a response code as an error
// -----------------------------------------------------------------------------
package axi_pkg;

  localparam int AXI_LEN_BITS   = 8;
  localparam int AXI_SIZE_BITS  = 3;
  localparam int AXI_BURST_BITS = 2;
  localparam int AXI_RESP_BITS  = 2;

  localparam logic [AXI_BURST_BITS-1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [AXI_RESP_BITS-1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam logic [AXI_SIZE_BITS-1:0]  AXI_SIZE_WORD  = 3'b010;
  // Every transaction is a single beat, so AxLEN (beats minus one) is zero.
  localparam logic [AXI_LEN_BITS-1:0]   AXI_LEN_SINGLE = 8'd0;

  // Master transaction sequencer states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WREQ  = 3'd3,
    WRESP = 3'd4
  } master_state_e;

  // Anything other than OKAY (EXOKAY is never requested) is reported to the CPU.
  function automatic logic resp_is_error(input logic [AXI_RESP_BITS-1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_master_wrapper_if.sv
// -----------------------------------------------------------------------------
// axi_master_wrapper_if
// AXI4 bus bundle between the CPU master wrapper and the downstream slave.
//   AW: AWID AWADDR AWLEN AWSIZE AWBURST AWVALID / AWREADY
//   W : WDATA WSTRB WLAST WVALID / WREADY
//   B : BID BRESP BVALID / BREADY
//   AR: ARID ARADDR ARLEN ARSIZE ARBURST ARVALID / ARREADY
//   R : RID RDATA RRESP RLAST RVALID / RREADY
// Modports: master (drives requests, takes responses) and slave (the reverse).
// -----------------------------------------------------------------------------
interface axi_master_wrapper_if
  import axi_pkg::*;
#(
  parameter int ID_BITS   = 4,
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32
);

  localparam int STRB_BITS = DATA_BITS / 8;

  // Write address channel
  logic [ID_BITS-1:0]        AWID;
  logic [ADDR_BITS-1:0]      AWADDR;
  logic [AXI_LEN_BITS-1:0]   AWLEN;
  logic [AXI_SIZE_BITS-1:0]  AWSIZE;
  logic [AXI_BURST_BITS-1:0] AWBURST;
  logic                      AWVALID;
  logic                      AWREADY;

  // Write data channel
  logic [DATA_BITS-1:0]      WDATA;
  logic [STRB_BITS-1:0]      WSTRB;
  logic                      WLAST;
  logic                      WVALID;
  logic                      WREADY;

  // Write response channel
  logic [ID_BITS-1:0]        BID;
  logic [AXI_RESP_BITS-1:0]  BRESP;
  logic                      BVALID;
  logic                      BREADY;

  // Read address channel
  logic [ID_BITS-1:0]        ARID;
  logic [ADDR_BITS-1:0]      ARADDR;
  logic [AXI_LEN_BITS-1:0]   ARLEN;
  logic [AXI_SIZE_BITS-1:0]  ARSIZE;
  logic [AXI_BURST_BITS-1:0] ARBURST;
  logic                      ARVALID;
  logic                      ARREADY;

  // Read data channel
  logic [ID_BITS-1:0]        RID;
  logic [DATA_BITS-1:0]      RDATA;
  logic [AXI_RESP_BITS-1:0]  RRESP;
  logic                      RLAST;
  logic                      RVALID;
  logic                      RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

endinterface

// File: rtl/axi_master_wrapper.sv
// -----------------------------------------------------------------------------
// axi_master_wrapper
// Turns a simple CPU load/store port into single-beat AXI4 transactions, one
// outstanding at a time. The CPU is held with cpu_stall until the response for
// its access returns; the response cycle itself ("done" cycle) has stall low,
// so the CPU can advance on the following clock edge.
//
// Ports:
//   clk        clock
//   ARSTN      asynchronous reset, active high
//   cpu_req    access request, held by the CPU while cpu_stall is high
//   cpu_we     1 = store, 0 = load
//   cpu_addr   byte address
//   cpu_wdata  store data
//   cpu_wstrb  store byte enables
//   cpu_rdata  load data, valid in the done cycle and held until the next load
//   cpu_stall  CPU must hold its request
//   cpu_err    one-cycle pulse: non-OKAY response on the completed access
//   m_axi      AXI4 master side of the bus bundle
// -----------------------------------------------------------------------------
module axi_master_wrapper
  import axi_pkg::*;
#(
  parameter int                 ID_BITS   = 4,
  parameter logic [ID_BITS-1:0] MASTER_ID = '0,
  parameter int                 ADDR_BITS = 32,
  parameter int                 DATA_BITS = 32,
  localparam int                STRB_BITS = DATA_BITS / 8
) (
  input  logic                  clk,
  input  logic                  ARSTN,

  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_BITS-1:0]  cpu_addr,
  input  logic [DATA_BITS-1:0]  cpu_wdata,
  input  logic [STRB_BITS-1:0]  cpu_wstrb,
  output logic [DATA_BITS-1:0]  cpu_rdata,
  output logic                  cpu_stall,
  output logic                  cpu_err,

  axi_master_wrapper_if.master  m_axi
);

  master_state_e state, state_next;

  // Request copy taken when the access is accepted in IDLE; the CPU side is
  // not trusted to stay stable afterwards.
  logic [ADDR_BITS-1:0] addr_q;
  logic                 we_q;
  logic [DATA_BITS-1:0] wdata_q;
  logic [STRB_BITS-1:0] wstrb_q;
  logic [DATA_BITS-1:0] rdata_q;

  // Per-channel completion flags for the write address/data pair.
  logic aw_done, w_done;

  logic ar_valid, r_ready, aw_valid, w_valid, b_ready;
  logic ar_fire, aw_fire, w_fire;
  logic r_done, b_done;
  logic aw_complete, w_complete;

  // Handshake terms. r_done only fires on the final beat; a non-last beat is
  // simply accepted and dropped.
  assign ar_fire     = ar_valid && m_axi.ARREADY;
  assign aw_fire     = aw_valid && m_axi.AWREADY;
  assign w_fire      = w_valid  && m_axi.WREADY;
  assign r_done      = r_ready  && m_axi.RVALID && m_axi.RLAST;
  assign b_done      = b_ready  && m_axi.BVALID;

  // A write channel counts as complete if it finished earlier or is
  // handshaking right now, so AW and W may finish in any order or together.
  assign aw_complete = aw_done || aw_fire;
  assign w_complete  = w_done  || w_fire;

  // State register, cleared asynchronously so a reset aborts any access
  // immediately and every VALID/READY falls with it.
  always_ff @(posedge clk or posedge ARSTN) begin
    if (ARSTN) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection: a single pass through address then response for
  // reads, and the AW/W pair then response for writes.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          state_next = cpu_we ? WREQ : RADDR;
        end
      end
      RADDR: begin
        if (ar_fire) begin
          state_next = RDATA;
        end
      end
      RDATA: begin
        if (r_done) begin
          state_next = IDLE;
        end
      end
      WREQ: begin
        if (aw_complete && w_complete) begin
          state_next = WRESP;
        end
      end
      WRESP: begin
        if (b_done) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode. The done cycle drops the stall combinationally and
  // forwards the read data and response status straight from the bus so the
  // CPU sees them in that same cycle.
  always_comb begin
    ar_valid  = 1'b0;
    r_ready   = 1'b0;
    aw_valid  = 1'b0;
    w_valid   = 1'b0;
    b_ready   = 1'b0;
    cpu_stall = 1'b1;
    cpu_err   = 1'b0;
    cpu_rdata = rdata_q;
    case (state)
      IDLE: begin
        cpu_stall = cpu_req;
      end
      RADDR: begin
        ar_valid = 1'b1;
      end
      RDATA: begin
        r_ready = 1'b1;
        if (r_done) begin
          cpu_stall = 1'b0;
          cpu_err   = resp_is_error(m_axi.RRESP);
          cpu_rdata = m_axi.RDATA;
        end
      end
      WREQ: begin
        aw_valid = !aw_done;
        w_valid  = !w_done;
      end
      WRESP: begin
        b_ready = 1'b1;
        if (b_done) begin
          cpu_stall = 1'b0;
          cpu_err   = resp_is_error(m_axi.BRESP);
        end
      end
      default: begin
        cpu_stall = cpu_req;
      end
    endcase
  end

  // Accept the CPU request in IDLE, and keep the most recent load result so
  // cpu_rdata stays stable between loads.
  always_ff @(posedge clk or posedge ARSTN) begin
    if (ARSTN) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state == IDLE && cpu_req) begin
        addr_q  <= cpu_addr;
        we_q    <= cpu_we;
        wdata_q <= cpu_wdata;
        wstrb_q <= cpu_wstrb;
      end
      if (r_done && !we_q) begin
        rdata_q <= m_axi.RDATA;
      end
    end
  end

  // Remember which write channel already handshook so its VALID stays low
  // while the other one is still waiting; both clear when the write response
  // completes the access.
  always_ff @(posedge clk or posedge ARSTN) begin
    if (ARSTN) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (b_done) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state == WREQ) begin
      if (aw_fire) begin
        aw_done <= 1'b1;
      end
      if (w_fire) begin
        w_done <= 1'b1;
      end
    end
  end

  // Bus drive: handshake bits from the decode above, payload from the
  // accepted request, and fixed single-beat word INCR attributes.
  assign m_axi.ARVALID = ar_valid;
  assign m_axi.ARID    = MASTER_ID;
  assign m_axi.ARADDR  = addr_q;
  assign m_axi.ARLEN   = AXI_LEN_SINGLE;
  assign m_axi.ARSIZE  = AXI_SIZE_WORD;
  assign m_axi.ARBURST = AXI_BURST_INCR;
  assign m_axi.RREADY  = r_ready;

  assign m_axi.AWVALID = aw_valid;
  assign m_axi.AWID    = MASTER_ID;
  assign m_axi.AWADDR  = addr_q;
  assign m_axi.AWLEN   = AXI_LEN_SINGLE;
  assign m_axi.AWSIZE  = AXI_SIZE_WORD;
  assign m_axi.AWBURST = AXI_BURST_INCR;

  assign m_axi.WVALID  = w_valid;
  assign m_axi.WDATA   = wdata_q;
  assign m_axi.WSTRB   = wstrb_q;
  assign m_axi.WLAST   = 1'b1;

  assign m_axi.BREADY  = b_ready;

endmodule

// File: tb/tb_axi_master_wrapper.sv
// -----------------------------------------------------------------------------
// tb_axi_master_wrapper
// Directed bench for axi_master_wrapper. A configurable slave answers each
// channel after a programmable number of wait cycles; a per-cycle compare
// process checks the wrapper against transaction-level rules, and each
// directed access also checks hand-computed stall counts and results.
// -----------------------------------------------------------------------------
module tb_axi_master_wrapper;
  import axi_pkg::*;

  localparam int ID_BITS   = 4;
  localparam int ADDR_BITS = 32;
  localparam int DATA_BITS = 32;
  localparam int STRB_BITS = DATA_BITS / 8;
  localparam logic [ID_BITS-1:0] MASTER_ID = 4'd0;

  logic                 clk = 1'b0;
  logic                 ARSTN;
  logic                 cpu_req;
  logic                 cpu_we;
  logic [ADDR_BITS-1:0] cpu_addr;
  logic [DATA_BITS-1:0] cpu_wdata;
  logic [STRB_BITS-1:0] cpu_wstrb;
  logic [DATA_BITS-1:0] cpu_rdata;
  logic                 cpu_stall;
  logic                 cpu_err;

  int n_checks = 0;
  int n_errors = 0;

  axi_master_wrapper_if #(.ID_BITS(ID_BITS), .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) m_axi ();

  axi_master_wrapper #(
    .ID_BITS(ID_BITS), .MASTER_ID(MASTER_ID), .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)
  ) dut (
    .clk(clk), .ARSTN(ARSTN),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_err(cpu_err),
    .m_axi(m_axi)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Slave response configuration for the current access.
  int             cfg_ar_wait, cfg_r_gap, cfg_aw_wait, cfg_w_wait, cfg_b_gap;
  bit             cfg_r_extra;
  logic [31:0]    cfg_rdata;
  logic [1:0]     cfg_rresp, cfg_bresp;

  // Transaction the CPU currently presents.
  logic           exp_we;
  logic [31:0]    exp_addr, exp_wdata;
  logic [3:0]     exp_wstrb;

  // Slave: drives its handshake/response signals on the falling edge. A READY
  // or VALID it raised last falling edge was consumed at the rising edge in
  // between, because the master side is always waiting by then.
  int  ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  bit  r_pend, aw_got, w_got;
  always @(negedge clk) begin
    if (ARSTN) begin
      m_axi.ARREADY = 0; m_axi.AWREADY = 0; m_axi.WREADY = 0;
      m_axi.RVALID = 0; m_axi.RLAST = 0; m_axi.RDATA = '0; m_axi.RRESP = '0; m_axi.RID = '0;
      m_axi.BVALID = 0; m_axi.BRESP = '0; m_axi.BID = '0;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      r_pend = 0; aw_got = 0; w_got = 0;
    end else begin
      if (m_axi.ARREADY) begin
        m_axi.ARREADY = 0; ar_cnt = 0; r_pend = 1; r_cnt = 0;
      end else if (m_axi.ARVALID) begin
        if (ar_cnt >= cfg_ar_wait) m_axi.ARREADY = 1; else ar_cnt++;
      end
      if (m_axi.RVALID) begin
        if (m_axi.RLAST) begin
          m_axi.RVALID = 0; m_axi.RLAST = 0; r_pend = 0;
        end else begin
          m_axi.RLAST = 1; m_axi.RDATA = cfg_rdata;
        end
      end else if (r_pend) begin
        if (r_cnt >= cfg_r_gap) begin
          m_axi.RVALID = 1; m_axi.RLAST = !cfg_r_extra; m_axi.RRESP = cfg_rresp;
          m_axi.RID = 4'd5;
          m_axi.RDATA = cfg_r_extra ? 32'h0BAD0BAD : cfg_rdata;
        end else r_cnt++;
      end
      if (m_axi.AWREADY) begin
        m_axi.AWREADY = 0; aw_got = 1;
      end else if (m_axi.AWVALID && !aw_got) begin
        if (aw_cnt >= cfg_aw_wait) m_axi.AWREADY = 1; else aw_cnt++;
      end
      if (m_axi.WREADY) begin
        m_axi.WREADY = 0; w_got = 1;
      end else if (m_axi.WVALID && !w_got) begin
        if (w_cnt >= cfg_w_wait) m_axi.WREADY = 1; else w_cnt++;
      end
      if (m_axi.BVALID) begin
        m_axi.BVALID = 0; aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      end else if (aw_got && w_got) begin
        if (b_cnt >= cfg_b_gap) begin
          m_axi.BVALID = 1; m_axi.BRESP = cfg_bresp; m_axi.BID = 4'd9;
        end else b_cnt++;
      end
    end
  end

  // Compare process: transaction-level rules checked every cycle.
  //  - stall is high exactly while a request is presented and its response
  //    (final R beat or B) is not on the bus this cycle
  //  - err pulses only with a non-OKAY final response; rdata tracks the last load
  //  - VALIDs carry the presented request, hold until accepted, drop after
  //  - each completed access used exactly one handshake on its own channels
  logic [31:0] model_rdata = '0;
  int          n_ar = 0, n_aw = 0, n_w = 0;
  logic        prev_rst = 1'b1;
  logic        prev_arv = 0, prev_arr = 0, prev_awv = 0, prev_awr = 0, prev_wv = 0, prev_wr = 0;
  always begin
    logic done_rd, done_wr, exp_stall, exp_err;
    @(negedge clk); #1;
    done_rd = !ARSTN && m_axi.RVALID && m_axi.RLAST;
    done_wr = !ARSTN && m_axi.BVALID;
    if (ARSTN || !cpu_req) begin
      checkOutput("quiet_arvalid", m_axi.ARVALID, 0);
      checkOutput("quiet_awvalid", m_axi.AWVALID, 0);
      checkOutput("quiet_wvalid",  m_axi.WVALID, 0);
      checkOutput("quiet_rready",  m_axi.RREADY, 0);
      checkOutput("quiet_bready",  m_axi.BREADY, 0);
    end
    exp_stall = cpu_req && !(done_rd || done_wr);
    checkOutput("cpu_stall", cpu_stall, exp_stall);
    exp_err = (done_rd && m_axi.RRESP != 2'b00) || (done_wr && m_axi.BRESP != 2'b00);
    checkOutput("cpu_err", cpu_err, exp_err);
    if (ARSTN) model_rdata = '0;
    checkOutput("cpu_rdata", cpu_rdata, done_rd ? m_axi.RDATA : model_rdata);
    if (done_rd) model_rdata = m_axi.RDATA;
    if (!ARSTN && m_axi.RVALID) checkOutput("rready_with_rvalid", m_axi.RREADY, 1);
    if (!ARSTN && m_axi.BVALID) checkOutput("bready_with_bvalid", m_axi.BREADY, 1);
    if (m_axi.ARVALID) begin
      checkOutput("araddr", m_axi.ARADDR, exp_addr);
      checkOutput("arid", m_axi.ARID, MASTER_ID);
      checkOutput("arlen", m_axi.ARLEN, 0);
      checkOutput("arsize", m_axi.ARSIZE, 3'b010);
      checkOutput("arburst", m_axi.ARBURST, 2'b01);
    end
    if (m_axi.AWVALID) begin
      checkOutput("awaddr", m_axi.AWADDR, exp_addr);
      checkOutput("awid", m_axi.AWID, MASTER_ID);
      checkOutput("awlen", m_axi.AWLEN, 0);
      checkOutput("awsize", m_axi.AWSIZE, 3'b010);
      checkOutput("awburst", m_axi.AWBURST, 2'b01);
    end
    if (m_axi.WVALID) begin
      checkOutput("wdata", m_axi.WDATA, exp_wdata);
      checkOutput("wstrb", m_axi.WSTRB, exp_wstrb);
      checkOutput("wlast", m_axi.WLAST, 1);
    end
    if (!ARSTN && !prev_rst) begin
      if (prev_arv && !prev_arr) checkOutput("arvalid_hold", m_axi.ARVALID, 1);
      if (prev_awv && !prev_awr) checkOutput("awvalid_hold", m_axi.AWVALID, 1);
      if (prev_wv  && !prev_wr)  checkOutput("wvalid_hold",  m_axi.WVALID, 1);
      if (prev_arv && prev_arr)  checkOutput("arvalid_drop", m_axi.ARVALID, 0);
      if (prev_awv && prev_awr)  checkOutput("awvalid_drop", m_axi.AWVALID, 0);
      if (prev_wv  && prev_wr)   checkOutput("wvalid_drop",  m_axi.WVALID, 0);
    end
    if (ARSTN) begin
      n_ar = 0; n_aw = 0; n_w = 0;
    end else begin
      if (m_axi.ARVALID && m_axi.ARREADY) n_ar++;
      if (m_axi.AWVALID && m_axi.AWREADY) n_aw++;
      if (m_axi.WVALID  && m_axi.WREADY)  n_w++;
    end
    if (done_rd || done_wr) begin
      checkOutput("ar_handshakes", n_ar, exp_we ? 0 : 1);
      checkOutput("aw_handshakes", n_aw, exp_we ? 1 : 0);
      checkOutput("w_handshakes",  n_w,  exp_we ? 1 : 0);
      n_ar = 0; n_aw = 0; n_w = 0;
    end
    prev_rst = ARSTN;
    prev_arv = m_axi.ARVALID; prev_arr = m_axi.ARREADY;
    prev_awv = m_axi.AWVALID; prev_awr = m_axi.AWREADY;
    prev_wv  = m_axi.WVALID;  prev_wr  = m_axi.WREADY;
  end

  // Present one CPU access and program the slave's timing for it. Called just
  // after a rising edge.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input int ar_wait, input int r_gap,
                               input bit r_extra, input logic [31:0] rdata, input logic [1:0] rresp,
                               input int aw_wait, input int w_wait, input int b_gap, input logic [1:0] bresp);
    cfg_ar_wait = ar_wait; cfg_r_gap = r_gap; cfg_r_extra = r_extra; cfg_rdata = rdata;
    cfg_rresp = rresp; cfg_aw_wait = aw_wait; cfg_w_wait = w_wait; cfg_b_gap = b_gap; cfg_bresp = bresp;
    exp_we = we; exp_addr = addr; exp_wdata = wdata; exp_wstrb = wstrb;
    cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_wstrb = wstrb; cpu_req = 1'b1;
  endtask

  // Wait (bounded) for the done cycle; report stall-high cycles seen and the
  // done-cycle results, then step past it and optionally release the request.
  task automatic waitForDone(input bit hold, output int stall_cycles,
                             output logic [31:0] rd, output logic err);
    bit seen = 0;
    stall_cycles = 0; rd = '0; err = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk); #1;
      if (cpu_stall) stall_cycles++;
      else begin seen = 1; rd = cpu_rdata; err = cpu_err; end
    end
    if (!seen) checkOutput("done_timeout", 0, 1);
    @(posedge clk); #1;
    if (!hold) cpu_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          stalls;
    logic [31:0] rd;
    logic        err;
    ARSTN = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
    cfg_ar_wait = 0; cfg_r_gap = 0; cfg_r_extra = 0; cfg_rdata = '0; cfg_rresp = '0;
    cfg_aw_wait = 0; cfg_w_wait = 0; cfg_b_gap = 0; cfg_bresp = '0;
    exp_we = 0; exp_addr = '0; exp_wdata = '0; exp_wstrb = '0;

    // Reset: stall follows cpu_req, bus quiet, results zero.
    repeat (2) @(posedge clk); #1;
    cpu_req = 1'b1;
    @(negedge clk); #1;
    checkOutput("rst_stall_follows_req", cpu_stall, 1);
    checkOutput("rst_arvalid", m_axi.ARVALID, 0);
    checkOutput("rst_rdata", cpu_rdata, 32'h0);
    checkOutput("rst_err", cpu_err, 0);
    @(posedge clk); #1;
    cpu_req = 1'b0; ARSTN = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Read: AR accepted at once, final beat two cycles after the handshake.
    applyStimulus(0, 32'h0000_1000, '0, '0, 0, 1, 0, 32'hDEADBEEF, 2'b00, 0, 0, 0, 2'b00);
    waitForDone(0, stalls, rd, err);
    checkOutput("rd1_stall_cycles", stalls, 3);
    checkOutput("rd1_rdata", rd, 32'hDEADBEEF);
    checkOutput("rd1_err", err, 0);
    @(negedge clk); #1;
    checkOutput("rd1_rdata_held", cpu_rdata, 32'hDEADBEEF);

    // Write: AW and W accepted in the same cycle, B one idle cycle later.
    @(posedge clk); #1;
    applyStimulus(1, 32'h0000_2004, 32'h1234_5678, 4'b0011, 0, 0, 0, '0, 2'b00, 0, 0, 1, 2'b00);
    waitForDone(0, stalls, rd, err);
    checkOutput("wr1_stall_cycles", stalls, 3);
    checkOutput("wr1_err", err, 0);
    checkOutput("wr1_rdata_unchanged", rd, 32'hDEADBEEF);

    // Write: W accepted first, AW three cycles later.
    applyStimulus(1, 32'h0000_3008, 32'hA5A5_0F0F, 4'b1111, 0, 0, 0, '0, 2'b00, 3, 0, 0, 2'b00);
    repeat (3) begin @(negedge clk); #1; end
    checkOutput("wr2_wvalid_dropped", m_axi.WVALID, 0);
    checkOutput("wr2_awvalid_held", m_axi.AWVALID, 1);
    checkOutput("wr2_no_bready_yet", m_axi.BREADY, 0);
    waitForDone(0, stalls, rd, err);
    checkOutput("wr2_stall_cycles", stalls + 3, 5);
    checkOutput("wr2_err", err, 0);

    // Write with SLVERR: err for exactly the done cycle.
    applyStimulus(1, 32'h0000_400C, 32'hFFFF_0000, 4'b1100, 0, 0, 0, '0, 2'b00, 1, 2, 0, 2'b10);
    waitForDone(0, stalls, rd, err);
    checkOutput("wr3_stall_cycles", stalls, 4);
    checkOutput("wr3_err_pulse", err, 1);
    @(negedge clk); #1;
    checkOutput("wr3_err_cleared", cpu_err, 0);

    // Read: AR waits one cycle, a non-last beat is ignored, final beat DECERR.
    @(posedge clk); #1;
    applyStimulus(0, 32'h0000_5010, '0, '0, 1, 0, 1, 32'hCAFE_F00D, 2'b11, 0, 0, 0, 2'b00);
    waitForDone(0, stalls, rd, err);
    checkOutput("rd2_stall_cycles", stalls, 4);
    checkOutput("rd2_rdata", rd, 32'hCAFE_F00D);
    checkOutput("rd2_err", err, 1);

    // Reset mid-read while waiting for data; then a clean read.
    applyStimulus(0, 32'h0000_6000, '0, '0, 0, 3, 0, 32'h1111_2222, 2'b00, 0, 0, 0, 2'b00);
    repeat (3) begin @(negedge clk); #1; end
    checkOutput("rd3_rready_before_reset", m_axi.RREADY, 1);
    #2;
    ARSTN = 1'b1; cpu_req = 1'b0;
    #1;
    checkOutput("abort_rready", m_axi.RREADY, 0);
    checkOutput("abort_arvalid", m_axi.ARVALID, 0);
    checkOutput("abort_err", cpu_err, 0);
    checkOutput("abort_stall", cpu_stall, 0);
    checkOutput("abort_rdata", cpu_rdata, 32'h0);
    repeat (2) @(posedge clk); #1;
    ARSTN = 1'b0;
    @(posedge clk); #1;
    applyStimulus(0, 32'h0000_7000, '0, '0, 0, 0, 0, 32'h55AA_33CC, 2'b00, 0, 0, 0, 2'b00);
    waitForDone(0, stalls, rd, err);
    checkOutput("rd4_stall_cycles", stalls, 2);
    checkOutput("rd4_rdata", rd, 32'h55AA_33CC);

    // Back-to-back read then write with the request held: the write is
    // accepted right after the read's done cycle, so its latency is minimal.
    applyStimulus(0, 32'h0000_0040, '0, '0, 0, 0, 0, 32'h0F0F_0F0F, 2'b00, 0, 0, 0, 2'b00);
    waitForDone(1, stalls, rd, err);
    checkOutput("b2b_rd_stall_cycles", stalls, 2);
    checkOutput("b2b_rd_rdata", rd, 32'h0F0F_0F0F);
    applyStimulus(1, 32'h0000_0044, 32'h8765_4321, 4'b0101, 0, 0, 0, '0, 2'b00, 0, 0, 0, 2'b00);
    waitForDone(0, stalls, rd, err);
    checkOutput("b2b_wr_stall_cycles", stalls, 2);
    checkOutput("b2b_wr_err", err, 0);
    checkOutput("b2b_wr_rdata_held", rd, 32'h0F0F_0F0F);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
